serial_adder_param: RTL
=======================

Name: serial_adder_param

Overview:
- Parametrised, multi-cycle successor to the combinational 8-bit adder.
- Adds or subtracts two WIDTH-bit operands with carry/borrow-in, processing BPC bits per clock, LSB first.
- Uses a start/busy/done handshake.
- Sits beside the existing combinational arithmetic blocks where area matters more than latency.

Parameters:
- WIDTH, 8, operand width in bits; must be ≥ 2.
- BPC, 1, bits processed per cycle; must divide WIDTH exactly. Number of steps STEPS = WIDTH/BPC.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  first operand; sampled on the accepting edge only.
- b  input  WIDTH  second operand; sampled on the accepting edge only.
- carryin  input  1  carry-in (add) or borrow-in (subtract); sampled on the accepting edge.
- sub  input  1  0 = add, 1 = subtract; sampled on the accepting edge.
- busy  output  1  high while a computation is in progress.
- done  output  1  one-cycle pulse when out becomes valid.
- out  output  WIDTH+1  result; bit WIDTH is carry-out (add) or not-borrow (subtract).

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; busy = 0, done = 0, out = 0; internal operand, carry and step registers cleared. Reset mid-computation abandons the computation and does not produce done.
- States: IDLE, RUN, DONE.
- IDLE, start = 1 at an edge:
  - latch A = a and B = sub ? ~b : b;
  - latch carry c = sub ? ~carryin : carryin;
  - step counter = 0; go to RUN; busy = 1 after that edge.
- RUN, each edge:
  - Add the low BPC bits of A and B plus c.
  - Shift the BPC sum bits into the result register from the MSB side.
  - Update c with the carry out of that BPC-bit slice; shift A and B right by BPC.
  - Increment the counter.
  - On the edge that completes step STEPS-1: out[WIDTH-1:0] = assembled sum, out[WIDTH] = final c; go to DONE.
- DONE (one cycle): done = 1, busy = 0.
  - If start = 1 at the next edge, a new computation is accepted and the block goes to RUN (back-to-back).
  - Otherwise the block goes to IDLE.
- Latency: if start is accepted at edge k, done is high in the cycle after edge k+STEPS and low again after edge k+STEPS+1.
- out is updated only on the final step edge. It holds its value through DONE and IDLE, and through the whole next computation, until that computation's final step edge.
- Arithmetic:
  - Add: out = a + b + carryin, WIDTH+1 bits, no overflow loss.
  - Subtract: out[WIDTH-1:0] = (a − b − carryin) mod 2^WIDTH; out[WIDTH] = 1 iff a ≥ b + carryin (unsigned).
- start while busy (RUN) is ignored: no restart, and operands are not re-latched.
- Input changes on a, b, carryin and sub after the accepting edge have no effect on the current computation.
- start held high continuously: computations run back-to-back, one every STEPS+1 cycles.
- The first step runs on the edge after acceptance; the acceptance edge itself only loads registers.

Test Plan:
- WIDTH=8, BPC=1, start with a=0xFF, b=0x01, carryin=0, sub=0 → done exactly 8 cycles after the accepting edge; out = 9'h100.
- WIDTH=8, BPC=1, add: a=0x40, b=0x41, carryin=1 → out = 9'h082. Then sub: a=0x08, b=0x08, carryin=0 → out = 9'h100. Then sub: a=0x07, b=0x08, carryin=0 → out = 9'h0FF (borrow, bit8 = 0).
- WIDTH=8, BPC=4: a=0x19, b=0x19, carryin=0 → done 2 cycles after acceptance; out = 9'h032. WIDTH=16, BPC=4: a=0xFFFF, b=0x0000, carryin=1 → out = 17'h10000 after 4 cycles.
- Pulse start again 3 cycles into a WIDTH=8, BPC=1 run, with different operands → first result unaffected (out = original sum), done pulses once, busy continuous.
- Drop rst_n low for 1 cycle mid-RUN, off the clock edge → busy, done and out go to 0 immediately. No done pulse follows. A fresh start after release computes correctly.
- Hold start high with changing operands → done every STEPS+1 cycles; each out matches the operands present at its own accepting edge.

Source files
------------

// File: rtl/serial_adder_param.sv
// Serial add/subtract of two WIDTH-bit operands, BPC bits per clock, LSB first.
// Latency: done pulses in the cycle after edge k+STEPS when start is accepted at edge k.
// No backpressure: start is only honoured in IDLE or DONE and ignored while busy.
module serial_adder_param #(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   out
);
    localparam int STEPS = WIDTH / BPC;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc;
    logic             c;
    logic [CW-1:0]    cnt;
    logic [BPC:0]     slice;
    logic [WIDTH-1:0] acc_nxt;
    logic             last;
    logic             accept;

    // Sum bits enter from the MSB side so after STEPS shifts the LSB slice sits at bit 0.
    always_comb begin
        slice   = {1'b0, opa[BPC-1:0]} + {1'b0, opb[BPC-1:0]} + {{BPC{1'b0}}, c};
        acc_nxt = (acc >> BPC) | (WIDTH'(slice[BPC-1:0]) << (WIDTH - BPC));
    end

    assign last   = (cnt == CW'(STEPS - 1));
    assign accept = start && ((state == IDLE) || (state == DONE));
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            opa   <= '0;
            opb   <= '0;
            acc   <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            out   <= '0;
        end else if (accept) begin
            // Subtraction is a + ~b + ~borrow; the final carry is then "not borrow".
            opa   <= a;
            opb   <= sub ? ~b : b;
            c     <= sub ? ~carryin : carryin;
            cnt   <= '0;
            state <= RUN;
        end else begin
            case (state)
                RUN: begin
                    acc <= acc_nxt;
                    opa <= opa >> BPC;
                    opb <= opb >> BPC;
                    c   <= slice[BPC];
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        out   <= {slice[BPC], acc_nxt};
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
